// File: rtl/vga_pkg.sv
`default_nettype none
// =============================================================================
// vga_pkg : screen geometry, ASCII codes and term_writer state encoding
// Revision: 1.0
// =============================================================================
package vga_pkg;

  localparam int N_COL         = 80;
  localparam int N_ROW         = 30;
  localparam int N_COL_WIDTH   = 7;
  localparam int N_ROW_WIDTH   = 5;
  localparam int N_CHARS_WIDTH = 12;

  localparam logic [7:0] ASC_BS    = 8'h08;
  localparam logic [7:0] ASC_TAB   = 8'h09;
  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_FF    = 8'h0C;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_TILDE = 8'h7E;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage
`default_nettype wire

// File: rtl/clear_seq.sv
`default_nettype none
// =============================================================================
// clear_seq : row-major cell sweep counter, (0,0) .. (N_COL-1,N_ROW-1)
// Revision: 1.0
// =============================================================================
module clear_seq #(
  parameter int N_COL       = 80,
  parameter int N_ROW       = 30,
  parameter int N_COL_WIDTH = 7,
  parameter int N_ROW_WIDTH = 5
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  output logic                   done_o,
  output logic [N_COL_WIDTH-1:0] col_o,
  output logic [N_ROW_WIDTH-1:0] row_o
);

  localparam logic [N_COL_WIDTH-1:0] COL_LAST = N_COL_WIDTH'(N_COL - 1);
  localparam logic [N_ROW_WIDTH-1:0] ROW_LAST = N_ROW_WIDTH'(N_ROW - 1);
  localparam logic [N_COL_WIDTH-1:0] COL_ONE  = N_COL_WIDTH'(1);
  localparam logic [N_ROW_WIDTH-1:0] ROW_ONE  = N_ROW_WIDTH'(1);

  logic                   active_q, active_d;
  logic [N_COL_WIDTH-1:0] col_q, col_d;
  logic [N_ROW_WIDTH-1:0] row_q, row_d;

  assign done_o = active_q && (col_q == COL_LAST) && (row_q == ROW_LAST);
  assign col_o  = col_q;
  assign row_o  = row_q;

  always_comb begin
    active_d = active_q;
    col_d    = col_q;
    row_d    = row_q;
    if (start_i) begin
      active_d = 1'b1;
      col_d    = '0;
      row_d    = '0;
    end else if (active_q) begin
      if (done_o) begin
        active_d = 1'b0;
        col_d    = '0;
        row_d    = '0;
      end else if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = row_q + ROW_ONE;
      end else begin
        col_d = col_q + COL_ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
    end else begin
      active_q <= active_d;
      col_q    <= col_d;
      row_q    <= row_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/term_writer.sv
`default_nettype none
// =============================================================================
// term_writer : uart byte stream to single-cell screen writes with a text cursor
// Optional TERM_TAB_EN enables TAB (0x09). Revision: 1.0
// =============================================================================
module term_writer #(
  parameter int         N_COL       = vga_pkg::N_COL,
  parameter int         N_ROW       = vga_pkg::N_ROW,
  parameter int         N_COL_WIDTH = vga_pkg::N_COL_WIDTH,
  parameter int         N_ROW_WIDTH = vga_pkg::N_ROW_WIDTH,
  parameter logic [6:0] CLR_CHAR    = 7'h20
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rx_valid_i,
  input  logic [7:0]             rx_data_i,
  output logic                   wr_en_o,
  output logic [N_COL_WIDTH-1:0] col_w_o,
  output logic [N_ROW_WIDTH-1:0] row_w_o,
  output logic [6:0]             din_o,
  output logic [N_COL_WIDTH-1:0] cur_col_o,
  output logic [N_ROW_WIDTH-1:0] cur_row_o,
  output logic                   busy_o,
  output logic                   overrun_o
);

  import vga_pkg::*;

  localparam logic [N_COL_WIDTH-1:0] COL_LAST = N_COL_WIDTH'(N_COL - 1);
  localparam logic [N_ROW_WIDTH-1:0] ROW_LAST = N_ROW_WIDTH'(N_ROW - 1);
  localparam logic [N_COL_WIDTH-1:0] COL_ONE  = N_COL_WIDTH'(1);
  localparam logic [N_ROW_WIDTH-1:0] ROW_ONE  = N_ROW_WIDTH'(1);

  logic [1:0]             state_q, state_d;
  logic                   rx_prev_q;
  logic [7:0]             hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic                   overrun_q, overrun_d;
  logic [N_COL_WIDTH-1:0] col_q, col_d;
  logic [N_ROW_WIDTH-1:0] row_q, row_d;

  logic                   accept, consume;
  logic [N_ROW_WIDTH-1:0] row_inc;
  logic                   dec_wr, dec_clear;
  logic [N_COL_WIDTH-1:0] dec_col, dec_ncol;
  logic [N_ROW_WIDTH-1:0] dec_row, dec_nrow;
  logic [6:0]             dec_din;
  logic                   seq_done;
  logic [N_COL_WIDTH-1:0] seq_col;
  logic [N_ROW_WIDTH-1:0] seq_row;

  // Every accepted byte goes through the hold register; IDLE/DRAIN consume it the next cycle.
  assign accept  = rx_valid_i && !rx_prev_q;
  assign consume = hold_full_q && ((state_q == ST_IDLE) || (state_q == ST_DRAIN));
  assign row_inc = (row_q == ROW_LAST) ? '0 : row_q + ROW_ONE;

`ifdef TERM_TAB_EN
  localparam logic [N_COL_WIDTH:0] COL_END = (N_COL_WIDTH+1)'(N_COL);
  logic [N_COL_WIDTH:0] tab_col;
  assign tab_col = ({1'b0, col_q} | (N_COL_WIDTH+1)'(7)) + (N_COL_WIDTH+1)'(1);
`endif

  always_comb begin
    dec_wr    = 1'b0;
    dec_clear = 1'b0;
    dec_col   = col_q;
    dec_row   = row_q;
    dec_din   = '0;
    dec_ncol  = col_q;
    dec_nrow  = row_q;
    if (!hold_q[7]) begin
      if ((hold_q >= ASC_SPACE) && (hold_q <= ASC_TILDE)) begin
        dec_wr  = 1'b1;
        dec_din = hold_q[6:0];
        if (col_q == COL_LAST) begin
          dec_ncol = '0;
          dec_nrow = row_inc;
        end else begin
          dec_ncol = col_q + COL_ONE;
        end
      end else begin
        case (hold_q)
          ASC_CR: dec_ncol = '0;
          ASC_LF: dec_nrow = row_inc;
          ASC_BS: begin
            if (col_q != '0) begin
              dec_ncol = col_q - COL_ONE;
              dec_col  = col_q - COL_ONE;
              dec_wr   = 1'b1;
              dec_din  = CLR_CHAR;
            end
          end
          ASC_FF: dec_clear = 1'b1;
`ifdef TERM_TAB_EN
          ASC_TAB: begin
            if (tab_col >= COL_END) begin
              dec_ncol = '0;
              dec_nrow = row_inc;
            end else begin
              dec_ncol = tab_col[N_COL_WIDTH-1:0];
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  clear_seq #(
    .N_COL       (N_COL),
    .N_ROW       (N_ROW),
    .N_COL_WIDTH (N_COL_WIDTH),
    .N_ROW_WIDTH (N_ROW_WIDTH)
  ) u_clear_seq (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (consume && dec_clear),
    .done_o  (seq_done),
    .col_o   (seq_col),
    .row_o   (seq_row)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (consume && dec_clear) state_d = ST_CLEAR;
      ST_CLEAR: if (seq_done) state_d = ST_DRAIN;
      ST_DRAIN: state_d = (consume && dec_clear) ? ST_CLEAR : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_en_o = 1'b0;
    col_w_o = '0;
    row_w_o = '0;
    din_o   = '0;
    busy_o  = 1'b0;
    if (state_q == ST_CLEAR) begin
      wr_en_o = 1'b1;
      col_w_o = seq_col;
      row_w_o = seq_row;
      din_o   = CLR_CHAR;
      busy_o  = 1'b1;
    end else if (consume && dec_wr) begin
      wr_en_o = 1'b1;
      col_w_o = dec_col;
      row_w_o = dec_row;
      din_o   = dec_din;
    end
  end

  // A byte consumed in the same cycle as a new accept is replaced, not overrun.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    overrun_d   = overrun_q;
    if ((state_q == ST_CLEAR) && seq_done) begin
      col_d = '0;
      row_d = '0;
    end else if (consume) begin
      col_d = dec_ncol;
      row_d = dec_nrow;
    end
    if (consume) hold_full_d = 1'b0;
    if (accept) begin
      hold_d      = rx_data_i;
      hold_full_d = 1'b1;
      if (hold_full_q && !consume) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_prev_q   <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      overrun_q   <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
    end else begin
      rx_prev_q   <= rx_valid_i;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      overrun_q   <= overrun_d;
      col_q       <= col_d;
      row_q       <= row_d;
    end
  end

  assign cur_col_o = col_q;
  assign cur_row_o = row_q;
  assign overrun_o = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_term_writer.sv
`default_nettype none
// =============================================================================
// tb_term_writer : directed + randomized check of term_writer against a screen model
// Revision: 1.0
// =============================================================================
module tb_term_writer;

  localparam int NC = 80;
  localparam int NR = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       wr_en, busy, overrun;
  logic [6:0] col_w, cur_col, din;
  logic [4:0] row_w, cur_row;

  term_writer dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rx_valid_i (rx_valid),
    .rx_data_i  (rx_data),
    .wr_en_o    (wr_en),
    .col_w_o    (col_w),
    .row_w_o    (row_w),
    .din_o      (din),
    .cur_col_o  (cur_col),
    .cur_row_o  (cur_row),
    .busy_o     (busy),
    .overrun_o  (overrun)
  );

  always #20 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: screen contents, cursor and expected write count.
  logic [6:0] mdl_scr [NR][NC];
  int mc = 0, mr = 0, m_writes = 0;

  // Buffer mirror fed by the DUT write port.
  logic [6:0] buf_scr [NR][NC];
  int stamp [NR][NC];
  int clear_gen = 0;
  int wr_count = 0, busy_count = 0;
  int lw_col = -1, lw_row = -1, lw_din = -1;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_count++;
    if (wr_en === 1'b1) begin
      wr_count++;
      lw_col = int'(col_w);
      lw_row = int'(row_w);
      lw_din = int'(din);
      if (int'(row_w) < NR && int'(col_w) < NC) begin
        buf_scr[row_w][col_w] = din;
        stamp[row_w][col_w] = clear_gen;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int extra, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    repeat (1 + extra) tick();
    rx_valid = 1'b0;
    repeat (1 + gap) tick();
  endtask

  task automatic m_apply(input logic [7:0] b);
    if (b[7]) return;
    if (b >= 8'h20 && b <= 8'h7E) begin
      mdl_scr[mr][mc] = b[6:0];
      m_writes++;
      mc++;
      if (mc == NC) begin mc = 0; mr = (mr + 1) % NR; end
    end else if (b == 8'h0D) mc = 0;
    else if (b == 8'h0A) mr = (mr + 1) % NR;
    else if (b == 8'h08) begin
      if (mc > 0) begin mc--; mdl_scr[mr][mc] = 7'h20; m_writes++; end
    end else if (b == 8'h0C) begin
      foreach (mdl_scr[r, c]) mdl_scr[r][c] = 7'h20;
      m_writes += NC * NR;
      mc = 0;
      mr = 0;
    end
`ifdef TERM_TAB_EN
    else if (b == 8'h09) begin
      mc = (mc / 8 + 1) * 8;
      if (mc >= NC) begin mc = 0; mr = (mr + 1) % NR; end
    end
`endif
  endtask

  task automatic put(input logic [7:0] b);
    send_byte(b, 0, 0);
    m_apply(b);
  endtask

  task automatic chk_cursor(input string tag);
    chk(tag, int'(cur_row) * 128 + int'(cur_col), mr * 128 + mc);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy === 1'b1 && k < 3000) begin tick(); k++; end
    chk("clear_bound", k < 3000, 1);
    repeat (3) tick();
  endtask

  initial begin
    int w0, b0, bad, hits, r, extra, gap;
    logic [7:0] b;

    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_cursor", {cur_row, cur_col}, 0);
    chk("rst_wport", {col_w, row_w, din}, 0);

    // 'A' with exact cycle timing
    rx_valid = 1'b1;
    rx_data  = 8'h41;
    @(posedge clk); #1;
    chk("a_wr_en", wr_en, 1);
    chk("a_wport", {col_w, row_w, din}, {7'd0, 5'd0, 7'h41});
    chk("a_cur_before", {cur_row, cur_col}, 0);
    @(posedge clk); #1;
    chk("a_wr_single", wr_en, 0);
    chk("a_cur_after", {cur_row, cur_col}, {5'd0, 7'd1});
    rx_valid = 1'b0;
    repeat (2) tick();
    m_apply(8'h41);

    // Bottom-right corner wrap
    put(8'h0D);
    repeat (NR - 1) put(8'h0A);
    repeat (NC - 1) put(8'h78);
    chk_cursor("corner_cur_pre");
    put(8'h5A);
    chk("corner_write", {lw_col, lw_row, lw_din}, {32'd79, 32'd29, 32'h5A});
    chk("corner_wrap", {cur_row, cur_col}, 0);

    // Backspace
    put(8'h41); put(8'h42); put(8'h08);
    chk("bs_write", {lw_col, lw_row, lw_din}, {32'd1, 32'd0, 32'h20});
    chk_cursor("bs_cur1");
    put(8'h08);
    chk("bs_write2", {lw_col, lw_row, lw_din}, {32'd0, 32'd0, 32'h20});
    w0 = wr_count;
    put(8'h08);
    chk("bs_col0_nowrite", wr_count - w0, 0);
    chk("bs_col0_cur", {cur_row, cur_col}, 0);

    // Full clear
    clear_gen = 1;
    w0 = wr_count;
    b0 = busy_count;
    put(8'h0C);
    wait_idle();
    chk("ff_busy_cycles", busy_count - b0, 2400);
    chk("ff_writes", wr_count - w0, 2400);
    hits = 0;
    bad = 0;
    foreach (buf_scr[rr, cc]) begin
      if (stamp[rr][cc] == 1) hits++;
      if (buf_scr[rr][cc] !== 7'h20) bad++;
    end
    chk("ff_cells_hit", hits, 2400);
    chk("ff_cells_blank", bad, 0);
    chk("ff_cursor", {cur_row, cur_col}, 0);

    // Byte held during clear
    send_byte(8'h0C, 0, 0);
    repeat (100) tick();
    chk("hold_busy", busy, 1);
    send_byte(8'h51, 0, 0);
    wait_idle();
    m_apply(8'h0C); m_apply(8'h51);
    chk("hold_write", {lw_col, lw_row, lw_din}, {32'd0, 32'd0, 32'h51});
    chk_cursor("hold_cur");
    chk("hold_no_overrun", overrun, 0);
    send_byte(8'h0C, 0, 0);
    repeat (100) tick();
    send_byte(8'h51, 0, 0);
    send_byte(8'h52, 0, 0);
    wait_idle();
    m_apply(8'h0C); m_apply(8'h52);
    chk("ovr_write", {lw_col, lw_row, lw_din}, {32'd0, 32'd0, 32'h52});
    chk("ovr_flag", overrun, 1);
    chk("ovr_writes", wr_count, m_writes);

    // TAB
    put(8'h0D); put(8'h61); put(8'h62); put(8'h63);
    w0 = wr_count;
    put(8'h09);
    chk_cursor("tab_col3");
    chk("tab_nowrite", wr_count - w0, 0);
    put(8'h0D);
    repeat (77) put(8'h6B);
    put(8'h09);
    chk_cursor("tab_col77");

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      b = 8'($urandom_range(32, 126));
      else if (r < 68) b = 8'h0D;
      else if (r < 76) b = 8'h0A;
      else if (r < 86) b = 8'h08;
      else if (r < 92) b = 8'h09;
      else if (r < 99) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h0C) b = 8'h0B;
      end else b = 8'h0C;
      extra = $urandom_range(0, 2);
      gap   = $urandom_range(0, 2);
      send_byte(b, extra, gap);
      if (b == 8'h0C) wait_idle();
      m_apply(b);
      chk("rnd_cursor", int'(cur_row) * 128 + int'(cur_col), mr * 128 + mc);
    end
    bad = 0;
    foreach (mdl_scr[rr, cc]) if (buf_scr[rr][cc] !== mdl_scr[rr][cc]) bad++;
    chk("rnd_screen", bad, 0);
    chk("rnd_writes", wr_count, m_writes);
    chk("rnd_overrun_sticky", overrun, 1);

    // Reset during a clear sweep, with a byte waiting in the hold register
    send_byte(8'h0C, 0, 0);
    repeat (200) tick();
    send_byte(8'h41, 0, 0);
    rst = 1'b1;
    tick();
    chk("rstclr_wr_en", wr_en, 0);
    chk("rstclr_busy", busy, 0);
    rst = 1'b0;
    w0 = wr_count;
    repeat (50) tick();
    chk("rstclr_no_writes", wr_count - w0, 0);
    chk("rstclr_cursor", {cur_row, cur_col}, 0);
    chk("rstclr_overrun", overrun, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
